alu_issue: RTL and testbench

- Initiator side of the core's integer ALU interface.
- Accepts decoded integer ops from decode over a valid/ready handshake and registers them into an EX stage.
- Drives the combinational ALU's func3/mode_flag/rs1/rs2 from that register and captures alu_rd.
- Queues results in a 2-entry writeback buffer toward the register file, forwarding pending results to newly accepted ops.

---
 rtl/alu_issue_pkg.sv | 31 +++
 rtl/alu_issue_wb_buf.sv | 82 ++++++++
 rtl/alu_issue.sv | 159 +++++++++++++++
 tb/tb_alu_issue.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared widths, ALU function codes and writeback-entry type for the integer ALU issue path.
package alu_issue_pkg;

    localparam int LEN_WORD     = 32;
    localparam int LEN_FUNC3    = 3;
    localparam int LEN_REG_ADDR = 5;

    localparam logic [LEN_FUNC3-1:0] FUNC3_ADD = 3'b000;
    localparam logic [LEN_FUNC3-1:0] FUNC3_SL  = 3'b001;
    localparam logic [LEN_FUNC3-1:0] FUNC3_XOR = 3'b100;
    localparam logic [LEN_FUNC3-1:0] FUNC3_SR  = 3'b101;
    localparam logic [LEN_FUNC3-1:0] FUNC3_OR  = 3'b110;
    localparam logic [LEN_FUNC3-1:0] FUNC3_AND = 3'b111;

    typedef logic [LEN_WORD-1:0]     word_t;
    typedef logic [LEN_REG_ADDR-1:0] reg_addr_t;
    typedef logic [LEN_FUNC3-1:0]    func3_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        word_t     data;
    } wb_entry_t;

    // Register x0 never produces or consumes an in-flight value.
    function automatic logic addr_hit(input reg_addr_t src, input logic dst_valid,
                                      input reg_addr_t dst);
        return dst_valid && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/alu_issue_wb_buf.sv
// Two-entry writeback FIFO; slot 0 is always the oldest entry. Both entries are
// exposed so the issue stage can compare against pending destinations.
module alu_issue_wb_buf
    import alu_issue_pkg::*;
#(
    parameter int DEPTH_WB = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  reg_addr_t push_addr,
    input  word_t     push_data,
    input  logic      pop,
    output logic      full,
    output wb_entry_t oldest,
    output wb_entry_t newest
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH_WB);

    logic [1:0] count_reg, count_next;
    reg_addr_t  addr_reg [2];
    reg_addr_t  addr_next [2];
    word_t      data_reg [2];
    word_t      data_next [2];
    logic [1:0] slot_valid;
    logic       pop_ok;
    logic       push_ok;
    logic       wr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot_valid
            assign slot_valid[gi] = (count_reg > 2'(gi));
        end
    endgenerate

    always_comb begin
        pop_ok     = pop & slot_valid[0];
        push_ok    = push & ((count_reg != FULL_COUNT) | pop_ok);
        // After an optional shift, the new entry lands just past the survivors.
        wr_idx     = count_reg[0] ^ pop_ok;
        addr_next  = addr_reg;
        data_next  = data_reg;
        if (pop_ok) begin
            addr_next[0] = addr_reg[1];
            data_next[0] = data_reg[1];
        end
        if (push_ok) begin
            addr_next[wr_idx] = push_addr;
            data_next[wr_idx] = push_data;
        end
        count_next = count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                addr_reg[i] <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < 2; i++) begin
                addr_reg[i] <= addr_next[i];
                data_reg[i] <= data_next[i];
            end
        end
    end

    always_comb begin
        full         = (count_reg == FULL_COUNT);
        oldest.valid = slot_valid[0];
        oldest.addr  = slot_valid[0] ? addr_reg[0] : '0;
        oldest.data  = slot_valid[0] ? data_reg[0] : '0;
        newest.valid = slot_valid[0];
        newest.addr  = addr_reg[slot_valid[1]];
        newest.data  = data_reg[slot_valid[1]];
    end

endmodule

// File: rtl/alu_issue.sv
// Integer ALU issue stage: decode handshake -> EX register -> ALU -> writeback buffer.
// Define ALU_ISSUE_FWD_EN for operand forwarding; otherwise dependent ops interlock.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH_WB = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LEN_FUNC3-1:0]    in_func3,
    input  logic                    in_mode_flag,
    input  logic [LEN_REG_ADDR-1:0] in_rd_addr,
    input  logic [LEN_REG_ADDR-1:0] in_rs1_addr,
    input  logic [LEN_REG_ADDR-1:0] in_rs2_addr,
    input  logic [LEN_WORD-1:0]     in_rs1_val,
    input  logic [LEN_WORD-1:0]     in_rs2_val,
    input  logic                    in_use_imm,
    input  logic [LEN_WORD-1:0]     in_imm,
    output logic [LEN_FUNC3-1:0]    alu_func3,
    output logic                    alu_mode_flag,
    output logic [LEN_WORD-1:0]     alu_rs1,
    output logic [LEN_WORD-1:0]     alu_rs2,
    input  logic [LEN_WORD-1:0]     alu_rd,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [LEN_REG_ADDR-1:0] wb_addr,
    output logic [LEN_WORD-1:0]     wb_data
);

    logic      ex_valid_reg, ex_valid_next;
    func3_t    ex_func3_reg, ex_func3_next;
    logic      ex_mode_reg, ex_mode_next;
    reg_addr_t ex_rd_reg, ex_rd_next;
    word_t     ex_op1_reg, ex_op1_next;
    word_t     ex_op2_reg, ex_op2_next;

    wb_entry_t wb_oldest;
    wb_entry_t wb_newest;
    logic      wb_full;
    logic      wb_pop;
    logic      wb_push;
    logic      ex_advance;
    logic      accept;
    logic      hazard;
    word_t     op1_val;
    word_t     op2_val;

    alu_issue_wb_buf #(
        .DEPTH_WB (DEPTH_WB)
    ) u_wb_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .push_addr (ex_rd_reg),
        .push_data (alu_rd),
        .pop       (wb_pop),
        .full      (wb_full),
        .oldest    (wb_oldest),
        .newest    (wb_newest)
    );

    assign wb_valid   = wb_oldest.valid;
    assign wb_addr    = wb_oldest.addr;
    assign wb_data    = wb_oldest.data;
    assign wb_pop     = wb_valid & wb_ready;
    // Results for x0 are dropped, but the op still leaves EX.
    assign ex_advance = ex_valid_reg & (!wb_full | wb_pop);
    assign wb_push    = ex_advance & !flush & (ex_rd_reg != '0);
    assign in_ready   = !rst & !flush & (!ex_valid_reg | ex_advance) & !hazard;
    assign accept     = in_valid & in_ready;

`ifdef ALU_ISSUE_FWD_EN
    // Newest producer wins: EX result, then newer WB entry, then older WB entry.
    function automatic word_t fwd_value(input reg_addr_t src, input word_t rf_val,
                                        input logic ex_v, input reg_addr_t ex_rd,
                                        input word_t ex_res, input wb_entry_t nw,
                                        input wb_entry_t od);
        if (addr_hit(src, ex_v, ex_rd))         return ex_res;
        if (addr_hit(src, nw.valid, nw.addr))   return nw.data;
        if (addr_hit(src, od.valid, od.addr))   return od.data;
        return rf_val;
    endfunction

    always_comb begin
        hazard  = 1'b0;
        op1_val = fwd_value(in_rs1_addr, in_rs1_val, ex_valid_reg, ex_rd_reg, alu_rd,
                            wb_newest, wb_oldest);
        op2_val = in_use_imm ? in_imm
                             : fwd_value(in_rs2_addr, in_rs2_val, ex_valid_reg, ex_rd_reg,
                                         alu_rd, wb_newest, wb_oldest);
    end
`else
    function automatic logic src_busy(input reg_addr_t src, input logic ex_v,
                                      input reg_addr_t ex_rd, input wb_entry_t nw,
                                      input wb_entry_t od);
        return addr_hit(src, ex_v, ex_rd) | addr_hit(src, nw.valid, nw.addr)
             | addr_hit(src, od.valid, od.addr);
    endfunction

    logic unused_fwd_data;
    assign unused_fwd_data = ^wb_newest.data;

    // Hold the op until every pending write to its sources has left the buffer.
    always_comb begin
        op1_val = in_rs1_val;
        op2_val = in_use_imm ? in_imm : in_rs2_val;
        hazard  = src_busy(in_rs1_addr, ex_valid_reg, ex_rd_reg, wb_newest, wb_oldest)
                | (!in_use_imm
                   & src_busy(in_rs2_addr, ex_valid_reg, ex_rd_reg, wb_newest, wb_oldest));
    end
`endif

    always_comb begin
        ex_valid_next = ex_valid_reg;
        ex_func3_next = ex_func3_reg;
        ex_mode_next  = ex_mode_reg;
        ex_rd_next    = ex_rd_reg;
        ex_op1_next   = ex_op1_reg;
        ex_op2_next   = ex_op2_reg;
        if (accept) begin
            ex_valid_next = 1'b1;
            ex_func3_next = in_func3;
            ex_mode_next  = in_mode_flag;
            ex_rd_next    = in_rd_addr;
            ex_op1_next   = op1_val;
            ex_op2_next   = op2_val;
        end else if (flush | ex_advance) begin
            ex_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg <= 1'b0;
            ex_func3_reg <= '0;
            ex_mode_reg  <= 1'b0;
            ex_rd_reg    <= '0;
            ex_op1_reg   <= '0;
            ex_op2_reg   <= '0;
        end else begin
            ex_valid_reg <= ex_valid_next;
            ex_func3_reg <= ex_func3_next;
            ex_mode_reg  <= ex_mode_next;
            ex_rd_reg    <= ex_rd_next;
            ex_op1_reg   <= ex_op1_next;
            ex_op2_reg   <= ex_op2_next;
        end
    end

    // The ALU sees a quiet zero operand set whenever EX is empty.
    assign alu_func3     = ex_valid_reg ? ex_func3_reg : '0;
    assign alu_mode_flag = ex_valid_reg & ex_mode_reg;
    assign alu_rs1       = ex_valid_reg ? ex_op1_reg : '0;
    assign alu_rs2       = ex_valid_reg ? ex_op2_reg : '0;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU closes the loop, expected
// writebacks are queued at accept and checked as the register file takes them.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_func3;
    logic        in_mode_flag;
    logic [4:0]  in_rd_addr;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [2:0]  alu_func3;
    logic        alu_mode_flag;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rf [32] = '{default: 32'd0};
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    alu_issue #(.DEPTH_WB(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func3      (in_func3),
        .in_mode_flag  (in_mode_flag),
        .in_rd_addr    (in_rd_addr),
        .in_rs1_addr   (in_rs1_addr),
        .in_rs2_addr   (in_rs2_addr),
        .in_rs1_val    (in_rs1_val),
        .in_rs2_val    (in_rs2_val),
        .in_use_imm    (in_use_imm),
        .in_imm        (in_imm),
        .alu_func3     (alu_func3),
        .alu_mode_flag (alu_mode_flag),
        .alu_rs1       (alu_rs1),
        .alu_rs2       (alu_rs2),
        .alu_rd        (alu_rd),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data)
    );

    function automatic logic [31:0] alu_model(input logic [2:0] f, input logic m,
                                              input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return m ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b100:  return a ^ b;
            3'b101:  return m ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_rd = alu_model(alu_func3, alu_mode_flag, alu_rs1, alu_rs2);

    // Register-file side: every accepted writeback is checked against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wb_valid && wb_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, required no writeback",
                         wb_addr, wb_data);
            end else begin
                e = exp_q.pop_front();
                if (wb_addr !== e.addr || wb_data !== e.data) begin
                    n_fail++;
                    $display("FAIL wb_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             wb_addr, wb_data, e.addr, e.data);
                end else begin
                    $display("wb  addr=%0d data=%h", wb_addr, wb_data);
                end
            end
            rf[wb_addr] = wb_data;
        end
    end

    // Presents one op and holds it until accepted; waited counts stalled cycles.
    task automatic send_op(input logic [2:0] f3, input logic mode, input logic [4:0] rd,
                           input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] v1, input logic [31:0] v2,
                           input logic use_imm, input logic [31:0] imm,
                           input logic from_rf, input logic expect_wb,
                           input logic [31:0] exp_data, output int waited);
        logic ready_seen;
        in_func3     = f3;
        in_mode_flag = mode;
        in_rd_addr   = rd;
        in_rs1_addr  = a1;
        in_rs2_addr  = a2;
        in_rs1_val   = v1;
        in_rs2_val   = v2;
        in_use_imm   = use_imm;
        in_imm       = imm;
        in_valid     = 1'b1;
        waited       = 0;
        ready_seen   = 1'b0;
        while (!ready_seen) begin
            @(negedge clk);
            #1;
            if (from_rf) begin
                in_rs1_val = rf[a1];
                in_rs2_val = rf[a2];
            end
            #1 ready_seen = in_ready;
            @(posedge clk);
            if (!ready_seen) begin
                waited++;
                if (waited > 40) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL accept_timeout: rd=%0d still not accepted after %0d cycles, required acceptance",
                             rd, waited);
                    #1 in_valid = 1'b0;
                    waited = -1;
                    return;
                end
            end
        end
        if (expect_wb) exp_q.push_back('{addr: rd, data: exp_data});
        $display("op  rd=%0d f3=%0d mode=%0d accepted after %0d stall cycles", rd, f3, mode, waited);
        #1 in_valid = 1'b0;
    endtask

    // Runs until the scoreboard and buffer are empty or the budget expires.
    task automatic drain(output int left);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || wb_valid) && cyc < 60) begin
            @(posedge clk);
            cyc++;
        end
        #1 left = exp_q.size();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        in_valid = 1'b1; in_func3 = 3'd0; in_mode_flag = 1'b0; in_rd_addr = 5'd1;
        in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rs1_val = 32'd1; in_rs2_val = 32'd1;
        in_use_imm = 1'b0; in_imm = 32'd0;
        #12;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b, required 0", wb_valid); end
        n_checks++;
        if ({alu_func3, alu_mode_flag, alu_rs1, alu_rs2} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_alu: got f3=%0d m=%b rs1=%h rs2=%h, required all 0",
                     alu_func3, alu_mode_flag, alu_rs1, alu_rs2);
        end
        n_checks++;
        if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_wb_bus: got addr=%0d data=%h, required 0/0", wb_addr, wb_data);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_wb_valid: got %b, required 0", wb_valid); end
    endtask

    task automatic test_add();
        int w;
        int left;
        wb_ready = 1'b1;
        send_op(3'd0, 1'b0, 5'd3, 5'd4, 5'd6, 32'd5, 32'd7, 1'b0, 32'd0, 1'b0, 1'b1, 32'd12, w);
        #1;
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_wb_early: got wb_valid=%b, required 0", wb_valid); end
        n_checks++;
        if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_func3 !== 3'd0) begin
            n_fail++;
            $display("FAIL add_alu_drive: got f3=%0d rs1=%h rs2=%h, required 0/5/7", alu_func3, alu_rs1, alu_rs2);
        end
        @(posedge clk); #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 32'd12) begin
            n_fail++;
            $display("FAIL add_wb: got v=%b addr=%0d data=%h, required 1/3/0000000c", wb_valid, wb_addr, wb_data);
        end
        drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL add_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_dependent();
        int w;
        int left;
        logic rf_src;
`ifdef ALU_ISSUE_FWD_EN
        rf_src = 1'b0;
`else
        rf_src = 1'b1;
`endif
        wb_ready = 1'b1;
        send_op(3'd0, 1'b0, 5'd1, 5'd11, 5'd12, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, 1'b1, 32'd7, w);
        send_op(3'd0, 1'b1, 5'd2, 5'd1, 5'd0, 32'd0, 32'd0, 1'b1, 32'd2, rf_src, 1'b1, 32'd5, w);
        n_checks++;
`ifdef ALU_ISSUE_FWD_EN
        if (w !== 0) begin n_fail++; $display("FAIL dep_stall: got %0d stall cycles, required 0", w); end
`else
        if (w !== 2) begin n_fail++; $display("FAIL dep_stall: got %0d stall cycles, required 2", w); end
`endif
        drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL dep_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_sra_imm();
        int w;
        int left;
        wb_ready = 1'b1;
        send_op(3'd5, 1'b1, 5'd7, 5'd14, 5'd0, 32'h8000_0000, 32'd0, 1'b1, 32'd4, 1'b0, 1'b1, 32'hF800_0000, w);
        #1;
        n_checks++;
        if (alu_rs2 !== 32'd4 || alu_mode_flag !== 1'b1) begin
            n_fail++; $display("FAIL sra_imm_operand: got rs2=%h m=%b, required 4/1", alu_rs2, alu_mode_flag);
        end
        send_op(3'd5, 1'b0, 5'd8, 5'd14, 5'd0, 32'h8000_0000, 32'd0, 1'b1, 32'd4, 1'b0, 1'b1, 32'h0800_0000, w);
        drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL sra_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_backpressure();
        int w;
        int left;
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_op(3'd0, 1'b0, 5'(16 + i), 5'd20, 5'd21, 32'(i + 1), 32'(i + 1), 1'b0, 32'd0,
                    1'b0, 1'b1, 32'(2 * (i + 1)), w);
        in_rd_addr = 5'd19; in_rs1_val = 32'd4; in_rs2_val = 32'd4; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b, required 0", c, in_ready); end
            @(posedge clk); #1;
        end
        n_checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd16) begin
            n_fail++; $display("FAIL bp_head: got v=%b addr=%0d, required 1/16", wb_valid, wb_addr);
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        send_op(3'd0, 1'b0, 5'd19, 5'd20, 5'd21, 32'd4, 32'd4, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, w);
        drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_rd_zero();
        int w;
        int left;
        wb_ready = 1'b1;
        send_op(3'd0, 1'b0, 5'd0, 5'd22, 5'd23, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, w);
        send_op(3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd100, 32'd1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd101, w);
        #1;
        n_checks++;
        if (alu_rs1 !== 32'd100 || w !== 0) begin
            n_fail++; $display("FAIL x0_operand: got rs1=%h stalls=%0d, required 00000064/0", alu_rs1, w);
        end
        send_op(3'd0, 1'b0, 5'd5, 5'd22, 5'd23, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0, 1'b1, 32'd3, w);
        drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL rd0_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_flush();
        int w;
        int left;
        wb_ready = 1'b0;
        send_op(3'd0, 1'b0, 5'd24, 5'd20, 5'd21, 32'd4, 32'd6, 1'b0, 32'd0, 1'b0, 1'b1, 32'd10, w);
        send_op(3'd6, 1'b0, 5'd25, 5'd20, 5'd21, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, w);
        flush = 1'b1;
        in_rd_addr = 5'd26; in_rs1_val = 32'd55; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (alu_rs1 !== 32'd0 || wb_valid !== 1'b1 || wb_addr !== 5'd24) begin
            n_fail++;
            $display("FAIL flush_state: got alu_rs1=%h wb_v=%b wb_addr=%0d, required 0/1/24", alu_rs1, wb_valid, wb_addr);
        end
        wb_ready = 1'b1;
        drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL flush_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_reset_mid();
        int w;
        wb_ready = 1'b0;
        send_op(3'd0, 1'b0, 5'd27, 5'd20, 5'd21, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, w);
        send_op(3'd0, 1'b0, 5'd28, 5'd20, 5'd21, 32'd2, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, w);
        in_rd_addr = 5'd29; in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got wb_valid=%b in_ready=%b, required 0/0", wb_valid, in_ready);
        end
        n_checks++;
        if (alu_rs1 !== 32'd0 || wb_addr !== 5'd0) begin
            n_fail++; $display("FAIL async_reset_bus: got alu_rs1=%h wb_addr=%0d, required 0/0", alu_rs1, wb_addr);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_wb: cycle %0d got %b, required 0", c, wb_valid); end
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int w;
        int left;
        logic [2:0]  f3;
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 7));
            m  = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            send_op(f3, m, 5'(27 + (i % 5)), 5'd20, 5'd21, a, b, 1'b0, 32'd0, 1'b0, 1'b1,
                    alu_model(f3, m, a, b), w);
            n_checks++;
            if (w !== 0) begin n_fail++; $display("FAIL b2b_stall: op %0d got %0d stalls, required 0", i, w); end
        end
        drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", left); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_dependent();
        test_sra_imm();
        test_backpressure();
        test_rd_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
